// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (8E1 when UART_RX_PARITY_EN is defined)
// with a first-word fall-through receive FIFO and sticky line-error flags.
//
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit and the PARITY state).
//
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   sIn        serial line, idle high, asynchronous to clk
//   dataRen    pop the head byte this cycle (ignored when empty)
//   errClr     clear the sticky flags; wins over a same-cycle set
//   data       FIFO head byte, 0 when empty
//   fifoEmpty  no bytes queued
//   fifoFull   FIFO holds FIFO_DEPTH bytes
//   frameErr   sticky: stop bit sampled low
//   overrun    sticky: good byte dropped because the FIFO was full
//   parityErr  sticky: parity mismatch (constant 0 without the macro)
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sIn,
  input  logic       dataRen,
  input  logic       errClr,
  output logic [7:0] data,
  output logic       fifoEmpty,
  output logic       fifoFull,
  output logic       frameErr,
  output logic       overrun,
  output logic       parityErr
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rxStateT;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} rxStateT;
`endif

  // two-flop synchronizer; reset to the idle line level so reset never looks like a start bit
  logic sMeta, sSync;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sMeta <= 1'b1;
      sSync <= 1'b1;
    end else begin
      sMeta <= sIn;
      sSync <= sMeta;
    end

  rxStateT          state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [2:0]       bitIdx, idxNext;
  logic [7:0]       shiftReg, shiftNext;
  logic             frameDone, stopOk, parOk, goodFrame;
`ifdef UART_RX_PARITY_EN
  logic             parBit, parNext;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
`ifdef UART_RX_PARITY_EN
      parBit   <= 1'b0;
`endif
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      bitIdx   <= idxNext;
      shiftReg <= shiftNext;
`ifdef UART_RX_PARITY_EN
      parBit   <= parNext;
`endif
    end

  always_comb begin
    stateNext = state;
    cntNext   = cnt + 1'b1;
    idxNext   = bitIdx;
    shiftNext = shiftReg;
`ifdef UART_RX_PARITY_EN
    parNext   = parBit;
`endif
    frameDone = 1'b0;
    stopOk    = 1'b0;
    case (state)
      IDLE: begin
        cntNext = '0;
        if (!sSync) stateNext = START;
      end
      // a start bit that is high again at mid-bit was a glitch
      START: if (cnt == HALF_CNT) begin
        cntNext   = '0;
        stateNext = sSync ? IDLE : DATA;
      end
      DATA: if (cnt == FULL_CNT) begin
        cntNext           = '0;
        shiftNext[bitIdx] = sSync;
        idxNext           = bitIdx + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bitIdx == 3'd7) stateNext = PARITY;
`else
        if (bitIdx == 3'd7) stateNext = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt == FULL_CNT) begin
        cntNext   = '0;
        parNext   = sSync;
        stateNext = STOP;
      end
`endif
      // leave at the mid-stop sample so a back-to-back start edge is not missed
      STOP: if (cnt == FULL_CNT) begin
        cntNext   = '0;
        frameDone = 1'b1;
        stopOk    = sSync;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign parOk = ~^{parBit, shiftReg};
`else
  assign parOk = 1'b1;
`endif
  assign goodFrame = frameDone & stopOk & parOk;

  // receive FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [PTR_W:0]   count;
  logic             push, pop;

  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pop       = dataRen & ~fifoEmpty;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign push      = goodFrame & (~fifoFull | pop);
  assign data      = fifoEmpty ? 8'h00 : mem[rdPtr];

  always_ff @(posedge clk)
    if (push) mem[wrPtr] <= shiftReg;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else if (errClr) begin
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (frameDone && !stopOk)            frameErr <= 1'b1;
      if (goodFrame && fifoFull && !pop)   overrun  <= 1'b1;
    end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst)
    if (rst)                           parityErr <= 1'b0;
    else if (errClr)                   parityErr <= 1'b0;
    else if (frameDone && stopOk && !parOk) parityErr <= 1'b1;
`else
  assign parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and checks every output on
// every cycle against a queue-based model of the receiver's observable behaviour.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // from the edge after which the start bit is driven to the edge sampling the stop bit:
  // 2 synchronizer edges + 1 detect edge, half a bit to mid-start, then one bit period per
  // data/parity/stop bit
  localparam int DONE_LAT = 3 + CPB/2 + CPB*(9 + PAR_BITS);

  logic clk = 1'b0, rst = 1'b1, sIn = 1'b1, dataRen = 1'b0, errClr = 1'b0;
  logic [7:0] data;
  logic fifoEmpty, fifoFull, frameErr, overrun, parityErr;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sIn(sIn), .dataRen(dataRen), .errClr(errClr),
    .data(data), .fifoEmpty(fifoEmpty), .fifoFull(fifoFull),
    .frameErr(frameErr), .overrun(overrun), .parityErr(parityErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] val;
    bit         good;
    bit         fErr;
    bit         pErr;
  } frameT;

  frameT      pend[$];
  logic [7:0] expQ[$];
  bit         expFrame, expOver, expPar;
  int         cyc = 0;
  int         checks = 0, errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // model: a frame's outcome lands on its stop-sample edge
  frameT mf;
  bit    mHave, mPop;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expQ.delete();
      pend.delete();
      expFrame = 0;
      expOver  = 0;
      expPar   = 0;
    end else begin
      cyc++;
      mHave = 0;
      mPop  = dataRen && (expQ.size() > 0);
      if (pend.size() > 0 && pend[0].due == cyc) begin
        mf    = pend.pop_front();
        mHave = 1;
      end
      if (mPop) void'(expQ.pop_front());
      if (errClr) begin
        expFrame = 0;
        expOver  = 0;
        expPar   = 0;
      end
      if (mHave) begin
        if (mf.good) begin
          if (expQ.size() < DEPTH) expQ.push_back(mf.val);
          else if (!errClr) expOver = 1;
        end
        if (mf.fErr && !errClr) expFrame = 1;
        if (mf.pErr && !errClr) expPar   = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("data",      data,      (expQ.size() > 0) ? expQ[0] : 8'h00);
    chk("fifoEmpty", {7'd0, fifoEmpty}, {7'd0, expQ.size() == 0});
    chk("fifoFull",  {7'd0, fifoFull},  {7'd0, expQ.size() == DEPTH});
    chk("frameErr",  {7'd0, frameErr},  {7'd0, expFrame});
    chk("overrun",   {7'd0, overrun},   {7'd0, expOver});
    chk("parityErr", {7'd0, parityErr}, {7'd0, expPar});
  end

  // all main-thread tasks start and end 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit doPop, input bit doClr);
    dataRen = doPop;
    errClr  = doClr;
    idle(1);
    dataRen = 0;
    errClr  = 0;
  endtask

  // nPeriods < full frame length aborts the frame part way
  task automatic sendFrame(input logic [7:0] v, input bit stopV, input bit parFlip, input int nPeriods);
    bit   bits[11];
    int   nb;
    bit   p, parGood;
    nb      = 0;
    bits[nb++] = 1'b0;
    for (int i = 0; i < 8; i++) bits[nb++] = v[i];
    p       = (^v) ^ parFlip;
    parGood = 1;
`ifdef UART_RX_PARITY_EN
    bits[nb++] = p;
    parGood    = ((^v) ^ p) == 1'b0;
`endif
    bits[nb++] = stopV;
    pend.push_back('{due: cyc + DONE_LAT, val: v, good: stopV && parGood,
                     fErr: !stopV, pErr: stopV && !parGood});
    for (int i = 0; i < nb && i < nPeriods; i++) begin
      sIn = bits[i];
      idle(CPB);
    end
    sIn = 1'b1;
  endtask

  bit rndOn;

  initial begin
    idle(3);
    chk("rst.data",  data, 8'h00);
    chk("rst.empty", {7'd0, fifoEmpty}, 8'd1);
    chk("rst.full",  {7'd0, fifoFull},  8'd0);
    chk("rst.flags", {5'd0, frameErr, overrun, parityErr}, 8'd0);
    rst = 0;
    idle(5);

    // single good byte, then pop it
    sendFrame(8'hA5, 1, 0, 99);
    chk("a5.data",  data, 8'hA5);
    chk("a5.empty", {7'd0, fifoEmpty}, 8'd0);
    pulse(1, 0);
    chk("a5.popEmpty", {7'd0, fifoEmpty}, 8'd1);
    chk("a5.popData",  data, 8'h00);

    // short low glitch in idle
    sIn = 0;
    idle(5);
    sIn = 1;
    idle(30);
    chk("glitch.empty", {7'd0, fifoEmpty}, 8'd1);
    chk("glitch.flags", {5'd0, frameErr, overrun, parityErr}, 8'd0);

    // stop bit low
    sendFrame(8'h3C, 0, 0, 99);
    idle(24);
    chk("fe.flag",  {7'd0, frameErr},  8'd1);
    chk("fe.empty", {7'd0, fifoEmpty}, 8'd1);
    pulse(0, 1);
    chk("fe.clr", {7'd0, frameErr}, 8'd0);

    // five back-to-back frames into a four-deep FIFO
    for (int v = 1; v <= 5; v++) sendFrame(8'(v), 1, 0, 99);
    chk("ov.full", {7'd0, fifoFull}, 8'd1);
    chk("ov.flag", {7'd0, overrun},  8'd1);
    for (int v = 1; v <= 4; v++) begin
      chk("ov.pop", data, 8'(v));
      pulse(1, 0);
    end
    chk("ov.empty", {7'd0, fifoEmpty}, 8'd1);
    pulse(0, 1);
    chk("ov.clr", {7'd0, overrun}, 8'd0);

    // reset in the middle of a frame while a byte is queued
    sendFrame(8'h11, 1, 0, 99);
    idle(4);
    sendFrame(8'h77, 1, 0, 4);
    rst = 1;
    idle(2);
    chk("mr.data",  data, 8'h00);
    chk("mr.empty", {7'd0, fifoEmpty}, 8'd1);
    rst = 0;
    idle(5);
    sendFrame(8'h22, 1, 0, 99);
    chk("mr.after", data, 8'h22);
    pulse(1, 0);

`ifdef UART_RX_PARITY_EN
    sendFrame(8'h0F, 1, 0, 99);
    chk("par.ok", data, 8'h0F);
    pulse(1, 0);
    sendFrame(8'h0F, 1, 1, 99);
    chk("par.err",   {7'd0, parityErr}, 8'd1);
    chk("par.empty", {7'd0, fifoEmpty}, 8'd1);
    pulse(0, 1);
`endif

    // random traffic with concurrent pops and clears
    rndOn = 1;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          bit st, pf;
          st = ($urandom_range(0, 7) != 0);
          pf = ($urandom_range(0, 5) == 0);
          sendFrame(8'($urandom_range(0, 255)), st, pf, 99);
          if (!st) idle(24);
          else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 30));
        end
        rndOn = 0;
      end
      begin
        while (rndOn) begin
          dataRen = ($urandom_range(0, 5) == 0);
          errClr  = ($urandom_range(0, 40) == 0);
          idle(1);
        end
        dataRen = 0;
        errClr  = 0;
      end
    join

    idle(30);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
